char_result_uart_tx: RTL and testbench

// - Transmit end of the plate-recognition path: takes the eight match codes produced per frame
//   (province/city code plus seven 8-bit character codes) and sends them to the host as one

---
 rtl/char_result_uart_tx_pkg.sv | 17 +
 rtl/char_result_uart_tx_if.sv | 29 ++
 rtl/char_result_uart_tx_byte.sv | 66 ++++++
 rtl/char_result_uart_tx.sv | 123 ++++++++++++
 tb/tb_char_result_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_result_uart_tx_pkg.sv
// Shared constants and state encoding for the plate-result UART transmit path.
package char_pkg;

    localparam logic [7:0] PKT_HDR0  = 8'hAA;
    localparam logic [7:0] PKT_HDR1  = 8'h55;
    localparam logic [7:0] PKT_TAIL  = 8'h0D;
    localparam int         PKT_BYTES = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/char_result_uart_tx_if.sv
// Frame-side inputs and UART/status outputs of the plate-result transmitter.
interface char_result_uart_tx_if;
    logic        i_vs;
    logic [1:0]  frame_cnt;
    logic [15:0] char_result1;
    logic [7:0]  char_result2;
    logic [7:0]  char_result3;
    logic [7:0]  char_result4;
    logic [7:0]  char_result5;
    logic [7:0]  char_result6;
    logic [7:0]  char_result7;
    logic [7:0]  char_result8;
    logic        uart_tx;
    logic        busy;
    logic        pkt_done;
    logic        pkt_dropped;

    modport master (
        output i_vs, frame_cnt, char_result1, char_result2, char_result3, char_result4,
               char_result5, char_result6, char_result7, char_result8,
        input  uart_tx, busy, pkt_done, pkt_dropped
    );

    modport slave (
        input  i_vs, frame_cnt, char_result1, char_result2, char_result3, char_result4,
               char_result5, char_result6, char_result7, char_result8,
        output uart_tx, busy, pkt_done, pkt_dropped
    );
endinterface

// File: rtl/char_result_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. ready is also high in the last stop-bit cycle
// so a caller can chain bytes with no idle gap.
module uart_byte_tx
    import char_pkg::*;
#(
    parameter int CLKS_PER_BIT = 643
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          last_tick;

    assign last_tick = (cnt == LAST);
    assign ready     = (state == IDLE) || ((state == STOP) && last_tick);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (start && ready) begin
            state <= START;
            cnt   <= '0;
            tx    <= 1'b0;
        end else begin
            if (state != IDLE)
                cnt <= last_tick ? '0 : cnt + 1'b1;
            case (state)
                START: if (last_tick) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                DATA: if (last_tick) begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        tx <= shreg[bit_idx + 3'd1];
                    end
                end
                STOP: if (last_tick) state <= IDLE;
                default: tx <= 1'b1;
            endcase
        end
    end

    // Byte holding register carries no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (start && ready)
            shreg <= data;
    end
endmodule

// File: rtl/char_result_uart_tx.sv
// Captures the per-frame plate match codes at vs fall and sends them as a
// 12-byte UART packet: AA 55, nine payload bytes, XOR checksum.
module char_result_uart_tx
    import char_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = 643,
    parameter logic [1:0] TRIG_CNT       = 2'd3,
    parameter bit         SEND_ON_CHANGE = 1'b1
) (
    input  logic                  pixelclk,
    input  logic                  reset,
    char_result_uart_tx_if.slave  bus
);
    localparam logic [3:0] LAST_IDX = 4'(PKT_BYTES - 1);

    // Top-level phases: IDLE, CHECK, DATA (packet on the line), STOP (pkt_done cycle).
    state_t      state;
    logic        vs_d;
    logic        trig;
    logic [3:0]  byte_idx;
    logic [3:0]  next_idx;
    logic [71:0] snap;
    logic [71:0] last_sent;
    logic        last_valid;
    logic        suppress;
    logic [7:0]  chk;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_ready;
    logic        tx_line;
    logic        busy_r;
    logic        done_r;
    logic        drop_r;

    function automatic logic [7:0] checksum(input logic [71:0] s);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 9; k++)
            x ^= s[8*k +: 8];
        return x;
    endfunction

    function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [71:0] s,
                                            input logic [7:0] c);
        if (idx == 4'd0)       return PKT_HDR0;
        else if (idx == 4'd1)  return PKT_HDR1;
        else if (idx <= 4'd10) return s[8*(4'd10 - idx) +: 8];
        else if (idx == 4'd11) return c;
        else                   return PKT_TAIL;
    endfunction

    assign trig     = vs_d & ~bus.i_vs & (bus.frame_cnt == TRIG_CNT);
    assign chk      = checksum(snap);
    assign suppress = SEND_ON_CHANGE && last_valid && (snap == last_sent);
    assign next_idx = (state == CHECK) ? 4'd0 : byte_idx + 4'd1;
    assign tx_byte  = pkt_byte(next_idx, snap, chk);
    assign tx_start = ((state == CHECK) && !suppress) ||
                      ((state == DATA) && tx_ready && (byte_idx != LAST_IDX));

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vs_d       <= 1'b0;
            state      <= IDLE;
            byte_idx   <= '0;
            last_valid <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            vs_d   <= bus.i_vs;
            done_r <= 1'b0;
            drop_r <= trig && (state != IDLE);
            case (state)
                IDLE: if (trig) state <= CHECK;
                CHECK: begin
                    if (suppress) begin
                        state <= IDLE;
                    end else begin
                        busy_r   <= 1'b1;
                        byte_idx <= '0;
                        state    <= DATA;
                    end
                end
                DATA: if (tx_ready) begin
                    if (byte_idx == LAST_IDX) begin
                        state      <= STOP;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        last_valid <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload registers are data only: snapshot on accepted trigger, history on completion.
    always_ff @(posedge pixelclk) begin
        if ((state == IDLE) && trig)
            snap <= {bus.char_result1, bus.char_result2, bus.char_result3, bus.char_result4,
                     bus.char_result5, bus.char_result6, bus.char_result7, bus.char_result8};
        if ((state == DATA) && tx_ready && (byte_idx == LAST_IDX))
            last_sent <= snap;
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk   (pixelclk),
        .rst   (reset),
        .start (tx_start),
        .data  (tx_byte),
        .tx    (tx_line),
        .ready (tx_ready)
    );

    assign bus.uart_tx     = tx_line;
    assign bus.busy        = busy_r;
    assign bus.pkt_done    = done_r;
    assign bus.pkt_dropped = drop_r;
endmodule

// File: tb/tb_char_result_uart_tx.sv
// Randomised bench for char_result_uart_tx: line waveform checked against a packet model.
module tb_char_result_uart_tx;
    localparam int CPB   = 4;
    localparam int NCAP  = 600;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    char_result_uart_tx_if if_a ();
    char_result_uart_tx_if if_b ();

    char_result_uart_tx #(.CLKS_PER_BIT(CPB), .TRIG_CNT(2'd3), .SEND_ON_CHANGE(1'b1)) dut_a (
        .pixelclk (clk),
        .reset    (reset),
        .bus      (if_a.slave)
    );

    char_result_uart_tx #(.CLKS_PER_BIT(CPB), .TRIG_CNT(2'd3), .SEND_ON_CHANGE(1'b0)) dut_b (
        .pixelclk (clk),
        .reset    (reset),
        .bus      (if_b.slave)
    );

    int errors = 0;
    int checks = 0;

    logic       cap_tx   [NCAP];
    logic       cap_busy [NCAP];
    logic       cap_done [NCAP];
    logic       cap_drop [NCAP];
    logic [7:0] exp_b    [12];

    localparam logic [71:0] BASIC = {16'h1234, 56'h41424344454647};

    // Packet model: header, nine payload bytes (r1 high byte first), XOR of payload.
    function automatic void set_model(input logic [71:0] v);
        logic [7:0] x;
        x = 8'h00;
        exp_b[0] = 8'hAA;
        exp_b[1] = 8'h55;
        for (int k = 0; k < 9; k++) begin
            exp_b[2+k] = v[71-8*k -: 8];
            x = x ^ v[71-8*k -: 8];
        end
        exp_b[11] = x;
    endfunction

    // Expected line level at capture index i (cycle i+1 after the trigger cycle).
    function automatic logic exp_line(input int i);
        int c, p, b;
        logic [7:0] by;
        c = i + 1;
        if (c < 2) return 1'b1;
        p = (c - 2) / CPB;
        if (p >= 120) return 1'b1;
        b = p % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        by = exp_b[p / 10];
        return by[b-1];
    endfunction

    function automatic int wave_errs(input int n);
        int e;
        e = 0;
        for (int i = 0; i < n; i++)
            if (cap_tx[i] !== exp_line(i)) e++;
        return e;
    endfunction

    function automatic logic [7:0] decode(input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++)
            r[j] = cap_tx[2 + (k*10 + 1 + j)*CPB + CPB/2 - 1];
        return r;
    endfunction

    function automatic int count_ones_done(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_ones_drop(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (cap_drop[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic logic [71:0] rand_vec();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    task automatic drive(input int which, input logic vs, input logic [1:0] fc, input logic [71:0] v);
        if (which == 0) begin
            if_a.i_vs = vs; if_a.frame_cnt = fc; if_a.char_result1 = v[71:56];
            if_a.char_result2 = v[55:48]; if_a.char_result3 = v[47:40]; if_a.char_result4 = v[39:32];
            if_a.char_result5 = v[31:24]; if_a.char_result6 = v[23:16]; if_a.char_result7 = v[15:8];
            if_a.char_result8 = v[7:0];
        end else begin
            if_b.i_vs = vs; if_b.frame_cnt = fc; if_b.char_result1 = v[71:56];
            if_b.char_result2 = v[55:48]; if_b.char_result3 = v[47:40]; if_b.char_result4 = v[39:32];
            if_b.char_result5 = v[31:24]; if_b.char_result6 = v[23:16]; if_b.char_result7 = v[15:8];
            if_b.char_result8 = v[7:0];
        end
    endtask

    // Ends on the posedge where the trigger is evaluated true.
    task automatic fire(input int which, input logic [1:0] fc, input logic [71:0] v);
        @(negedge clk); drive(which, 1'b1, fc, v);
        @(negedge clk); drive(which, 1'b0, fc, v);
        @(posedge clk);
    endtask

    task automatic capture(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = (which == 0) ? if_a.uart_tx     : if_b.uart_tx;
            cap_busy[i] = (which == 0) ? if_a.busy        : if_b.busy;
            cap_done[i] = (which == 0) ? if_a.pkt_done    : if_b.pkt_done;
            cap_drop[i] = (which == 0) ? if_a.pkt_dropped : if_b.pkt_dropped;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (if_a.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", if_a.uart_tx); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", if_a.busy); end
        checks++; if (if_a.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", if_a.pkt_done); end
        checks++; if (if_a.pkt_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b want=0", if_a.pkt_dropped); end
        checks++; if (if_b.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_b got=%b want=1", if_b.uart_tx); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int e;
        e = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (if_a.uart_tx !== 1'b1 || if_a.busy !== 1'b0) e++;
        end
        checks++; if (e != 0) begin errors++; $display("FAIL idle_line bad_cycles=%0d want=0", e); end
        fire(0, 2'd2, BASIC);
        capture(0, 20);
        e = 0;
        for (int i = 0; i < 20; i++)
            if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_drop[i] !== 1'b0) e++;
        checks++; if (e != 0) begin errors++; $display("FAIL wrong_phase_trig bad_cycles=%0d want=0", e); end
    endtask

    task automatic test_basic_send();
        set_model(BASIC);
        fire(0, 2'd3, BASIC);
        capture(0, 490);
        checks++; if (cap_tx[0] !== 1'b1 || cap_tx[1] !== 1'b0) begin
            errors++; $display("FAIL start_latency got=%b%b want=10", cap_tx[0], cap_tx[1]);
        end
        checks++; if (cap_busy[1] !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", cap_busy[1]); end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (decode(k) !== exp_b[k]) begin
                errors++; $display("FAIL basic_byte%0d got=%h want=%h", k, decode(k), exp_b[k]);
            end
        end
        checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL basic_wave bad_cycles=%0d want=0", wave_errs(490)); end
        checks++; if (cap_done[481] !== 1'b1 || count_ones_done(490) != 1) begin
            errors++; $display("FAIL basic_done at481=%b pulses=%0d want=1,1", cap_done[481], count_ones_done(490));
        end
        checks++; if (cap_busy[485] !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b want=0", cap_busy[485]); end
    endtask

    task automatic test_repeat_suppress();
        logic [71:0] v2;
        int e;
        fire(0, 2'd3, BASIC);
        capture(0, 20);
        e = 0;
        for (int i = 0; i < 20; i++)
            if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) e++;
        checks++; if (e != 0) begin errors++; $display("FAIL suppress_same bad_cycles=%0d want=0", e); end
        v2 = BASIC;
        v2[31:24] = 8'h5A;
        set_model(v2);
        fire(0, 2'd3, v2);
        capture(0, 490);
        checks++; if (decode(11) !== exp_b[11]) begin errors++; $display("FAIL changed_chk got=%h want=%h", decode(11), exp_b[11]); end
        checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL changed_wave bad_cycles=%0d want=0", wave_errs(490)); end
        checks++; if (cap_done[481] !== 1'b1) begin errors++; $display("FAIL changed_done got=%b want=1", cap_done[481]); end
    endtask

    task automatic test_no_suppress();
        set_model(BASIC);
        for (int r = 0; r < 2; r++) begin
            fire(1, 2'd3, BASIC);
            capture(1, 490);
            checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL resend%0d_wave bad_cycles=%0d want=0", r, wave_errs(490)); end
            checks++; if (cap_done[481] !== 1'b1) begin errors++; $display("FAIL resend%0d_done got=%b want=1", r, cap_done[481]); end
        end
    endtask

    task automatic test_random_send();
        logic [71:0] v;
        for (int r = 0; r < 3; r++) begin
            v = rand_vec();
            set_model(v);
            fire(0, 2'd3, v);
            capture(0, 490);
            checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL rand%0d_wave bad_cycles=%0d want=0", r, wave_errs(490)); end
            checks++; if (cap_done[481] !== 1'b1) begin errors++; $display("FAIL rand%0d_done got=%b want=1", r, cap_done[481]); end
        end
    endtask

    task automatic test_busy_drop(output logic [71:0] sent);
        logic [71:0] v;
        v = rand_vec();
        sent = v;
        set_model(v);
        fire(0, 2'd3, v);
        fork
            capture(0, 490);
            begin
                repeat (100) @(negedge clk);
                drive(0, 1'b1, 2'd3, v);
                @(negedge clk);
                drive(0, 1'b0, 2'd3, ~v);
            end
        join
        checks++; if (cap_drop[101] !== 1'b1 || count_ones_drop(490) != 1) begin
            errors++; $display("FAIL drop_pulse at101=%b pulses=%0d want=1,1", cap_drop[101], count_ones_drop(490));
        end
        checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL drop_inflight_wave bad_cycles=%0d want=0", wave_errs(490)); end
        checks++; if (cap_done[481] !== 1'b1) begin errors++; $display("FAIL drop_done got=%b want=1", cap_done[481]); end
    endtask

    task automatic test_reset_mid_packet(input logic [71:0] prev);
        logic [71:0] v;
        v = rand_vec();
        fire(0, 2'd3, v);
        repeat (215) @(negedge clk);
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL midpkt_busy got=%b want=1", if_a.busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (if_a.uart_tx !== 1'b1 || if_a.busy !== 1'b0) begin
            errors++; $display("FAIL midpkt_reset tx=%b busy=%b want=1,0", if_a.uart_tx, if_a.busy);
        end
        reset = 1'b0;
        set_model(prev);
        fire(0, 2'd3, prev);
        capture(0, 490);
        checks++; if (wave_errs(490) != 0) begin errors++; $display("FAIL after_reset_wave bad_cycles=%0d want=0", wave_errs(490)); end
        checks++; if (cap_done[481] !== 1'b1) begin errors++; $display("FAIL after_reset_done got=%b want=1", cap_done[481]); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] va, vc;
        int n;
        va = rand_vec();
        set_model(va);
        fire(0, 2'd3, va);
        fork
            capture(0, 495);
            begin
                repeat (480) @(negedge clk);
                drive(0, 1'b1, 2'd3, va);
                repeat (2) @(negedge clk);
                drive(0, 1'b0, 2'd3, ~va);
            end
        join
        checks++; if (cap_done[481] !== 1'b1 || cap_drop[482] !== 1'b1) begin
            errors++; $display("FAIL b2b_coincident done=%b drop=%b want=1,1", cap_done[481], cap_drop[482]);
        end
        checks++; if (wave_errs(495) != 0) begin errors++; $display("FAIL b2b_no_restart bad_cycles=%0d want=0", wave_errs(495)); end

        vc = rand_vec();
        set_model(vc);
        fire(0, 2'd3, vc);
        fork
            capture(0, 500);
            begin
                repeat (481) @(negedge clk);
                drive(0, 1'b1, 2'd3, vc);
                repeat (2) @(negedge clk);
                drive(0, 1'b0, 2'd3, ~vc);
            end
        join
        checks++; if (wave_errs(484) != 0) begin errors++; $display("FAIL b2b_first_wave bad_cycles=%0d want=0", wave_errs(484)); end
        checks++; if (count_ones_drop(500) != 0 || cap_tx[484] !== 1'b0 || cap_busy[484] !== 1'b1) begin
            errors++; $display("FAIL b2b_next_accept drops=%0d tx=%b busy=%b want=0,0,1",
                                count_ones_drop(500), cap_tx[484], cap_busy[484]);
        end
        n = 0;
        while (if_a.busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 3000) begin errors++; $display("FAIL b2b_finish timeout busy=%b want=0", if_a.busy); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [71:0] sent;
        drive(0, 1'b1, 2'd0, 72'h0);
        drive(1, 1'b1, 2'd0, 72'h0);
        test_reset();
        test_idle();
        test_basic_send();
        test_repeat_suppress();
        test_no_suppress();
        test_random_send();
        test_busy_drop(sent);
        test_reset_mid_packet(sent);
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
